flash_wb_adapter: RTL
=====================

// Module: flash_wb_adapter
// PURPOSE
//  Wishbone classic slave sitting between the OpenMIPS data/instruction bus arbiter and the flash controller.
//  Turns 32-bit bus accesses into 16-bit flash operations on the controller's command interface:
//   - reads: two halfword reads;
//   - writes: up to two halfword programs;
//   - block erase: one command.
//  Sequences the controller's busy/ack handshake and applies a bounded timeout so the CPU never hangs.
// PARAMETERS
//  FLASH_AW  22           halfword address width on the controller side
//  TMO_W     27           width of the timeout counter
//  TMO_MAX   100_000_000  cycles to wait for ack per flash op (> worst-case erase at 50 MHz)
// PORTS
//  clk            in   1   single clock for the block
//  rst            in   1   reset: synchronous, active-high
//  wb_cyc_i       in   1   bus cycle
//  wb_stb_i       in   1   strobe
//  wb_we_i        in   1   1 = write/erase, 0 = read
//  wb_adr_i       in   32  byte address; [23]=1 selects erase space, [22:2] = word
//  wb_dat_i       in   32  write data
//  wb_sel_i       in   4   byte lane enables
//  wb_dat_o       out  32  read data (lane 0 = low halfword)
//  wb_ack_o       out  1   one-cycle completion
//  enable_read    out  1   one-cycle read command to controller
//  enable_write   out  1   one-cycle program command
//  enable_erase   out  1   one-cycle block erase command
//  input_addr     out  22  halfword address to controller
//  input_data     out  16  program data to controller
//  output_data    in   16  controller read data, valid in ack cycle
//  flash_busy     in   1   controller busy; no command issued while high
//  ack            in   1   controller one-cycle done pulse
//  tmo_flag       out  1   sticky: some op timed out; cleared only by rst
// BEHAVIOUR
//  Reset values: all outputs 0; FSM in IDLE; timeout counter 0.
//  FSM states: IDLE, ISSUE_LO, WAIT_LO, ISSUE_HI, WAIT_HI, DONE.
//  Address mapping: halfword address hw_addr = {wb_adr_i[22:2], h}, where h=0 is the low halfword ([15:0]).
//  IDLE:
//   - Accept a request when cyc&stb&!wb_ack_o.
//   - Latch adr, dat, sel and we into registers.
//   - Next state is ISSUE_LO; for a write with sel[1:0]==0, go directly to ISSUE_HI.
//   - A write with sel==0 goes to DONE, with no flash op.
//  ISSUE_x:
//   - Wait while flash_busy=1.
//   - Once flash_busy=0, pulse exactly one enable for one cycle.
//   - Drive input_addr and input_data from the latched request; both held stable until the WAIT_x ack.
//  Op selection:
//   - Read:  enable_read.
//   - Write: enable_write.
//     - input_data = the selected lanes; an unselected byte inside the halfword is driven 8'hFF (programming 1s leaves flash unchanged).
//   - Erase (we=1 and adr[23]=1):
//     - enable_erase at hw_addr {adr[22:2],0}.
//     - Single op; WAIT_LO then goes to DONE.
//  WAIT_x:
//   - On ack: for a read, capture output_data into wb_dat_o[15:0] or [31:16].
//   - WAIT_LO -> ISSUE_HI when the hi half is needed (read, or write with sel[3:2]!=0); otherwise -> DONE.
//   - WAIT_HI -> DONE.
//  Timeout:
//   - Counter runs in ISSUE_x and WAIT_x and clears on each state change.
//   - At TMO_MAX: set tmo_flag, force the data half to 16'hFFFF, proceed as if ack arrived.
//  DONE:
//   - wb_ack_o=1 for exactly one cycle if cyc is still high; then go to IDLE.
//   - Read latency on an idle controller: 2*(1+Tack)+2 cycles from stb to ack.
//  cyc dropped mid-op: the outstanding flash op completes (flash ops cannot be aborted); no wb_ack_o; return to IDLE.
//  ack in IDLE/ISSUE (stale ack from before reset): ignored.
//  rst mid-op:
//   - Immediate return to IDLE with all outputs 0.
//   - The controller may still be busy; the next ISSUE waits on flash_busy.
//  wb_dat_o holds its value after ack until the next read captures data.
// STRUCTURE
//  Shared package (flash_defs): FSM state encoding, FLASH_AW, op-code localparams (OP_RD/OP_WR/OP_ER), ERASE_SPACE_BIT=23.
//  One natural sub-module: flash_op_timer (load/clear, run, expire) wrapping the TMO_W counter.
//  Everything else lives in the single FSM plus datapath registers.
// TESTING
//  Bench: behavioural controller model with configurable busy/ack delay.
//  1 Read:
//   - adr=0x0000_0010; model returns 0x1234 at hw 8 and 0xABCD at hw 9.
//   - Expect: enable_read twice, input_addr 8 then 9; wb_dat_o=0xABCD1234; one ack.
//  2 Write:
//   - adr=0x0000_0004, dat=0xCAFE_BEEF, sel=4'b0110.
//   - Expect: program 0xBEFF at hw 2, then 0xFFFE at hw 3; one ack.
//  3 Erase:
//   - we=1, adr=0x0080_0100.
//   - Expect: single enable_erase with input_addr=0x000080, no enable_write; ack after the model's ack.
//  4 Busy / stale ack:
//   - flash_busy held high 50 cycles at request; stray ack while in IDLE.
//   - Expect: no enable issued until busy falls; stale ack ignored.
//  5 Timeout:
//   - Model never acks, TMO_MAX=100.
//   - Expect: wb_ack_o at 100+ cycles per half; wb_dat_o=0xFFFFFFFF; tmo_flag stays 1 until rst.
//  6 Aborts:
//   - Drop cyc in WAIT_LO: no wb_ack_o; FSM back in IDLE after the model's ack.
//   - Assert rst in WAIT_HI: all outputs 0 the next cycle.

Source files
------------

// File: rtl/flash_defs.sv
// Shared definitions for the Wishbone-to-flash adapter: FSM encoding, op codes and
// address-map constants.
package flash_defs;

  localparam int unsigned FLASH_AW        = 22;
  localparam int unsigned ERASE_SPACE_BIT = 23;

  localparam logic [1:0] OP_RD = 2'd0;
  localparam logic [1:0] OP_WR = 2'd1;
  localparam logic [1:0] OP_ER = 2'd2;

  typedef enum logic [2:0] {
    StIdle,
    StIssueLo,
    StWaitLo,
    StIssueHi,
    StWaitHi,
    StDone
  } state_e;

  // Unselected bytes are programmed as 1s so the flash cell is left untouched.
  function automatic logic [15:0] merge_half(input logic [15:0] d, input logic [1:0] sel);
    merge_half = {sel[1] ? d[15:8] : 8'hFF, sel[0] ? d[7:0] : 8'hFF};
  endfunction

endpackage

// File: rtl/flash_op_timer.sv
// Per-operation timeout counter; expire asserts once the count reaches TMO_MAX.
module flash_op_timer #(
  parameter int unsigned TMO_W   = 27,
  parameter int unsigned TMO_MAX = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expire
);

  logic [TMO_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (run && !expire) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expire = (cnt_q == TMO_W'(TMO_MAX));

endmodule

// File: rtl/flash_wb_adapter.sv
// Wishbone classic slave that splits 32-bit accesses into 16-bit flash controller
// commands, with a bounded wait on every controller operation.
module flash_wb_adapter #(
  parameter int unsigned FLASH_AW = flash_defs::FLASH_AW,
  parameter int unsigned TMO_W    = 27,
  parameter int unsigned TMO_MAX  = 100_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [31:0]         wb_adr_i,
  input  logic [31:0]         wb_dat_i,
  input  logic [3:0]          wb_sel_i,
  output logic [31:0]         wb_dat_o,
  output logic                wb_ack_o,
  output logic                enable_read,
  output logic                enable_write,
  output logic                enable_erase,
  output logic [FLASH_AW-1:0] input_addr,
  output logic [15:0]         input_data,
  input  logic [15:0]         output_data,
  input  logic                flash_busy,
  input  logic                ack,
  output logic                tmo_flag
);
  import flash_defs::*;

  state_e              state_q;
  logic [FLASH_AW-2:0] word_q;
  logic [31:0]         dat_q;
  logic [3:0]          sel_q;
  logic [1:0]          op_q;
  logic                abort_q;

  logic   in_issue, in_wait, is_hi, need_hi, expire, tmr_run, tmr_clear;
  state_e next_half;
  logic [15:0] wdata, cap;

  logic unused_adr;
  assign unused_adr = ^{wb_adr_i[31:24], wb_adr_i[1:0]};

  always_comb begin
    in_issue = (state_q == StIssueLo) || (state_q == StIssueHi);
    in_wait  = (state_q == StWaitLo) || (state_q == StWaitHi);
    is_hi    = (state_q == StIssueHi) || (state_q == StWaitHi);
    need_hi  = (op_q == OP_RD) || ((op_q == OP_WR) && (sel_q[3:2] != 2'b00));
    if (!wb_cyc_i || abort_q) begin
      next_half = StIdle;
    end else if (!is_hi && need_hi) begin
      next_half = StIssueHi;
    end else begin
      next_half = StDone;
    end
    tmr_run   = in_issue || in_wait;
    // Clear on every state change so each flash op gets a fresh budget.
    tmr_clear = !tmr_run || expire || (in_wait && ack)
                || (in_issue && (!flash_busy || !wb_cyc_i));
    wdata = is_hi ? merge_half(dat_q[31:16], sel_q[3:2]) : merge_half(dat_q[15:0], sel_q[1:0]);
    cap   = (in_wait && ack) ? output_data : 16'hFFFF;
  end

  flash_op_timer #(
    .TMO_W  (TMO_W),
    .TMO_MAX(TMO_MAX)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (tmr_clear),
    .run   (tmr_run),
    .expire(expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      word_q       <= '0;
      dat_q        <= '0;
      sel_q        <= '0;
      op_q         <= OP_RD;
      abort_q      <= 1'b0;
      wb_dat_o     <= '0;
      wb_ack_o     <= 1'b0;
      enable_read  <= 1'b0;
      enable_write <= 1'b0;
      enable_erase <= 1'b0;
      input_addr   <= '0;
      input_data   <= '0;
      tmo_flag     <= 1'b0;
    end else begin
      enable_read  <= 1'b0;
      enable_write <= 1'b0;
      enable_erase <= 1'b0;
      wb_ack_o     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (wb_cyc_i && wb_stb_i && !wb_ack_o) begin
            word_q  <= wb_adr_i[FLASH_AW:2];
            dat_q   <= wb_dat_i;
            sel_q   <= wb_sel_i;
            abort_q <= 1'b0;
            if (!wb_we_i) begin
              op_q    <= OP_RD;
              state_q <= StIssueLo;
            end else if (wb_adr_i[ERASE_SPACE_BIT]) begin
              op_q    <= OP_ER;
              state_q <= StIssueLo;
            end else begin
              op_q <= OP_WR;
              if (wb_sel_i == 4'b0000) begin
                state_q <= StDone;
              end else if (wb_sel_i[1:0] == 2'b00) begin
                state_q <= StIssueHi;
              end else begin
                state_q <= StIssueLo;
              end
            end
          end
        end
        StIssueLo, StIssueHi: begin
          if (!wb_cyc_i) begin
            state_q <= StIdle;
          end else if (expire) begin
            tmo_flag <= 1'b1;
            if (op_q == OP_RD) begin
              if (is_hi) wb_dat_o[31:16] <= cap;
              else       wb_dat_o[15:0]  <= cap;
            end
            state_q <= next_half;
          end else if (!flash_busy) begin
            enable_read  <= (op_q == OP_RD);
            enable_write <= (op_q == OP_WR);
            enable_erase <= (op_q == OP_ER);
            input_addr   <= {word_q, is_hi};
            input_data   <= (op_q == OP_WR) ? wdata : 16'h0000;
            state_q      <= is_hi ? StWaitHi : StWaitLo;
          end
        end
        StWaitLo, StWaitHi: begin
          // A started flash op cannot be aborted; remember the drop and finish it.
          if (!wb_cyc_i) abort_q <= 1'b1;
          if (ack || expire) begin
            if (!ack) tmo_flag <= 1'b1;
            if (op_q == OP_RD) begin
              if (is_hi) wb_dat_o[31:16] <= cap;
              else       wb_dat_o[15:0]  <= cap;
            end
            state_q <= next_half;
          end
        end
        StDone: begin
          wb_ack_o <= wb_cyc_i;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
